// File: rtl/spi_memory_bridge.sv
// SPI mode-0 slave that turns serial frames (command word + one data word, MSB first)
// into accesses on a synchronous data memory port. Burst mode: SPI_BRIDGE_AUTOINC_EN.
module spi_memory_bridge #(
  parameter int addresswidth = 7,
  parameter int width        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_writeEnable,
  output logic [width-1:0]        mem_dataIn,
  input  logic [width-1:0]        mem_dataOut,
  output logic                    done
);

  localparam int CMDW = addresswidth + 1;
  localparam int RXW  = (CMDW > width) ? CMDW : width;
  localparam int CNTW = $clog2(RXW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RD_WAIT,
    S_RD_LOAD,
    S_RD_SEND,
    S_WR_DATA,
    S_WR_COMMIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sclk_sync_q, sclk_sync_d;
  logic [1:0]              cs_sync_q, cs_sync_d;
  logic [1:0]              mosi_sync_q, mosi_sync_d;
  logic [CNTW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [RXW-2:0]          rx_q, rx_d;
  logic [width-1:0]        tx_q, tx_d;
  logic                    miso_q, miso_d;
  logic                    miso_oe_q, miso_oe_d;
  logic [addresswidth-1:0] addr_q, addr_d;
  logic                    we_q, we_d;
  logic [width-1:0]        din_q, din_d;
  logic                    done_q, done_d;
  logic                    armed_q, armed_d;

  logic           rise_evt;
  logic           fall_evt;
  logic           cs_high;
  logic           mosi_bit;
  logic [RXW-1:0] rx_shift;

  assign rise_evt = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall_evt = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_high  = cs_sync_q[1];
  assign mosi_bit = mosi_sync_q[1];
  assign rx_shift = {rx_q, mosi_bit};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    cs_sync_d   = {cs_sync_q[0], cs_n};
    mosi_sync_d = {mosi_sync_q[0], mosi};
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    din_d     = din_q;
    done_d    = 1'b0;
    // A frame may only start once cs_n has been seen high, so a frame cut by reset is ignored.
    armed_d   = armed_q | cs_high;

    if (cs_high) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
            armed_d   = 1'b0;
          end
        end
        S_CMD: begin
          if (rise_evt) begin
            rx_d = rx_shift[RXW-2:0];
            if (bit_cnt_q == CNTW'(CMDW - 1)) begin
              addr_d    = rx_shift[addresswidth:1];
              bit_cnt_d = '0;
              state_d   = rx_shift[0] ? S_RD_WAIT : S_WR_DATA;
            end else begin
              bit_cnt_d = bit_cnt_q + CNTW'(1);
            end
          end
        end
        S_RD_WAIT: state_d = S_RD_LOAD;
        S_RD_LOAD: begin
          tx_d      = mem_dataOut;
          miso_oe_d = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_RD_SEND;
        end
        S_RD_SEND: begin
          if (fall_evt) begin
            miso_d = tx_q[width-1];
            tx_d   = {tx_q[width-2:0], 1'b0};
            if (bit_cnt_q == CNTW'(width - 1)) begin
              done_d    = 1'b1;
              bit_cnt_d = '0;
`ifdef SPI_BRIDGE_AUTOINC_EN
              addr_d    = addr_q + addresswidth'(1);
              state_d   = S_RD_WAIT;
`else
              state_d   = S_DONE;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CNTW'(1);
            end
          end
        end
        S_WR_DATA: begin
          if (rise_evt) begin
            rx_d = rx_shift[RXW-2:0];
            if (bit_cnt_q == CNTW'(width - 1)) begin
              // Strobe and data registers load here so they are valid during WR_COMMIT.
              din_d     = rx_shift[width-1:0];
              we_d      = 1'b1;
              done_d    = 1'b1;
              bit_cnt_d = '0;
              state_d   = S_WR_COMMIT;
            end else begin
              bit_cnt_d = bit_cnt_q + CNTW'(1);
            end
          end
        end
        S_WR_COMMIT: begin
`ifdef SPI_BRIDGE_AUTOINC_EN
          addr_d  = addr_q + addresswidth'(1);
          state_d = S_WR_DATA;
`else
          state_d = S_DONE;
`endif
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // cs_n synchronizer resets to "selected" so a frame still in progress cannot arm a restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
      done_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      din_q       <= din_d;
      done_q      <= done_d;
      armed_q     <= armed_d;
    end
  end

  assign miso            = miso_q;
  assign miso_oe         = miso_oe_q;
  assign mem_address     = addr_q;
  assign mem_writeEnable = we_q;
  assign mem_dataIn      = din_q;
  assign done            = done_q;

endmodule
